// File: rtl/touch_key_events.sv
// ---------------------------------------------------------------------------
// touch_key_events: debounced single-cycle key events with hold-to-repeat,
// feeding a saturating running total.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module touch_key_events #(
  parameter int DEB_SAMPLES   = 4,
  parameter int REPEAT_DELAY  = 32,
  parameter int REPEAT_PERIOD = 8,
  parameter int SUM_W         = 14,
  parameter int MAX_TOTAL     = 9999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_stb,
  input  logic             t_five,
  input  logic             t_ten,
  input  logic             t_f_teen,
  input  logic             clear,
  output logic             key_valid,
  output logic [1:0]       key_code,
  output logic [SUM_W-1:0] total,
  output logic             saturated
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DEBOUNCE = 3'd1,
    S_PRESSED  = 3'd2,
    S_REPEAT   = 3'd3,
    S_RELEASE  = 3'd4
  } state_t;

  localparam logic [3:0]     c_deb    = 4'(DEB_SAMPLES);
  localparam logic [7:0]     c_delay  = 8'(REPEAT_DELAY);
  localparam logic [7:0]     c_period = 8'(REPEAT_PERIOD);
  localparam logic [SUM_W:0] c_max    = (SUM_W+1)'(MAX_TOTAL);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       hold_q, hold_d;
  logic [1:0]       cand_q, cand_d;
  logic             key_valid_q;
  logic [1:0]       key_code_q;
  logic [SUM_W-1:0] total_q, total_d;
  logic             saturated_q, saturated_d;

  logic [1:0]       code;
  logic             emit;
  logic [3:0]       cnt_inc;
  logic [7:0]       hold_inc;
  logic [7:0]       hold_lim;
  logic [3:0]       step;
  logic [SUM_W:0]   sum;
  logic [SUM_W:0]   capped;

  // Ambiguous samples (none or several keys) collapse to code 0.
  always_comb begin
    code = 2'd0;
    unique case ({t_f_teen, t_ten, t_five})
      3'b001:  code = 2'd1;
      3'b010:  code = 2'd2;
      3'b100:  code = 2'd3;
      default: code = 2'd0;
    endcase
  end

  assign cnt_inc  = cnt_q + 4'd1;
  assign hold_inc = hold_q + 8'd1;
  assign hold_lim = (state_q == S_PRESSED) ? c_delay : c_period;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    cand_d  = cand_q;
    emit    = 1'b0;
    if (sample_stb) begin
      case (state_q)
        S_IDLE: begin
          if (code != 2'd0) begin
            cand_d = code;
            cnt_d  = 4'd1;
            if (c_deb == 4'd1) begin
              emit    = 1'b1;
              hold_d  = 8'd0;
              state_d = S_PRESSED;
            end else begin
              state_d = S_DEBOUNCE;
            end
          end
        end
        S_DEBOUNCE: begin
          if (code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == c_deb) begin
              emit    = 1'b1;
              hold_d  = 8'd0;
              state_d = S_PRESSED;
            end
          end else if (code == 2'd0) begin
            state_d = S_IDLE;
          end else begin
            cand_d = code;
            cnt_d  = 4'd1;
          end
        end
        S_PRESSED, S_REPEAT: begin
          if (code == cand_q) begin
            hold_d = hold_inc;
            if (hold_inc == hold_lim) begin
              emit    = 1'b1;
              hold_d  = 8'd0;
              state_d = S_REPEAT;
            end
          end else begin
            // A single-sample release filter is already satisfied here.
            cnt_d   = (code == 2'd0) ? 4'd1 : 4'd0;
            state_d = (code == 2'd0 && c_deb == 4'd1) ? S_IDLE : S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (code == 2'd0) begin
            cnt_d = cnt_inc;
            if (cnt_inc == c_deb) state_d = S_IDLE;
          end else if (code == cand_q) begin
            hold_d  = 8'd0;
            state_d = S_PRESSED;
          end else begin
            cnt_d = 4'd0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    step = 4'd0;
    case (cand_d)
      2'd1:    step = 4'd5;
      2'd2:    step = 4'd10;
      2'd3:    step = 4'd15;
      default: step = 4'd0;
    endcase
  end

  assign sum    = {1'b0, total_q} + (SUM_W+1)'(step);
  assign capped = (sum > c_max) ? c_max : sum;

  always_comb begin
    total_d     = total_q;
    saturated_d = saturated_q;
    if (clear) begin
      total_d     = '0;
      saturated_d = 1'b0;
    end else if (emit) begin
      total_d     = capped[SUM_W-1:0];
      saturated_d = (capped == c_max);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      hold_q      <= 8'd0;
      cand_q      <= 2'd0;
      key_valid_q <= 1'b0;
      key_code_q  <= 2'd0;
      total_q     <= '0;
      saturated_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      cand_q      <= cand_d;
      key_valid_q <= emit;
      key_code_q  <= emit ? cand_d : 2'd0;
      total_q     <= total_d;
      saturated_q <= saturated_d;
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign total     = total_q;
  assign saturated = saturated_q;

endmodule

`default_nettype wire
